// File: rtl/decim_media.sv
// rtl/decim_media.sv - integrate-and-dump decimator, block average of 2**LOG2_M signed samples
module decim_media #(
  parameter int DATA_W = 32,
  parameter int LOG2_M = 3,
  parameter int ROUND  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] entrada,
  output logic signed [DATA_W-1:0] saida,
  output logic                     out_valid,
  output logic [LOG2_M-1:0]        cnt
);

  localparam int AW = DATA_W + LOG2_M;

  localparam logic [0:0] FILL      = 1'b0;
  localparam logic [0:0] DUMP_EDGE = 1'b1;

  // Rounding offset and saturation bound live in the guard-bit-wide domain.
  localparam logic signed [AW:0] HALF =
    (ROUND != 0) ? $signed((AW+1)'((1 << LOG2_M) >> 1)) : '0;
  localparam logic signed [AW:0] MAX_G =
    $signed({{(LOG2_M+2){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [DATA_W-1:0] MAX_OUT = {1'b0, {(DATA_W-1){1'b1}}};

  logic [1:0]              rst_sync;
  logic                    run;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    ext;
  logic signed [AW-1:0]    sum;
  logic signed [AW:0]      sum_g;
  logic signed [AW:0]      shifted;
  logic signed [DATA_W-1:0] dump_val;
  logic [0:0]              state;

  // Assertion is immediate; release reaches the datapath only after two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  always_comb begin
    ext     = {{LOG2_M{entrada[DATA_W-1]}}, entrada};
    sum     = acc + ext;
    sum_g   = {sum[AW-1], sum} + HALF;
    shifted = sum_g >>> LOG2_M;
    if (shifted > MAX_G) begin
      dump_val = MAX_OUT;
    end else begin
      dump_val = shifted[DATA_W-1:0];
    end
    state = (in_valid && (cnt == '1)) ? DUMP_EDGE : FILL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      saida     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (run) begin
        if (clear) begin
          acc <= '0;
          cnt <= '0;
        end else if (in_valid) begin
          case (state)
            FILL: begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
            DUMP_EDGE: begin
              saida     <= dump_val;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
            end
            default: begin
              acc <= '0;
              cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_decim_media.sv
// tb/tb_decim_media.sv - directed checks of decim_media, truncating and rounding builds side by side
module tb_decim_media;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [31:0] entrada = '0;

  logic signed [31:0] saida0, saida1;
  logic out_valid0, out_valid1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  decim_media #(.DATA_W(32), .LOG2_M(3), .ROUND(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .entrada(entrada), .saida(saida0), .out_valid(out_valid0), .cnt(cnt0)
  );

  decim_media #(.DATA_W(32), .LOG2_M(3), .ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .entrada(entrada), .saida(saida1), .out_valid(out_valid1), .cnt(cnt1)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(negedge clk) begin
    if (out_valid0) pulses0++;
    if (out_valid1) pulses1++;
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, return just after the rising edge that consumed it.
  task automatic step(input logic v, input logic signed [31:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    entrada  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [31:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    idle();
    idle();
  endtask

  task automatic expect_dump(input string tag, input logic signed [31:0] e0, input logic signed [31:0] e1);
    check({tag, "_ov0"}, out_valid0, 1);
    check({tag, "_ov1"}, out_valid1, 1);
    check({tag, "_saida0"}, saida0, e0);
    check({tag, "_saida1"}, saida1, e1);
    idle();
    check({tag, "_ov0_drop"}, out_valid0, 0);
    check({tag, "_saida0_hold"}, saida0, e0);
  endtask

  initial begin
    // Asynchronous assertion with the clock stopped.
    #2;
    reset = 1'b0;
    #1;
    check("rst_saida", saida0, 0);
    check("rst_ov", out_valid0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_saida_r1", saida1, 0);
    #4;
    reset = 1'b1;
    clk_en = 1'b1;

    // First edge after release must not accumulate.
    push(32'sd7);
    check("sync_edge1_cnt", cnt0, 0);
    idle();
    idle();

    // Constant 100.
    pulses0 = 0;
    for (int i = 1; i <= 8; i++) begin
      push(32'sd100);
      if (i < 8) begin
        check($sformatf("const_cnt%0d", i), cnt0, i);
        check($sformatf("const_ov%0d", i), out_valid0, 0);
      end else begin
        check("const_cnt_wrap", cnt0, 0);
      end
    end
    expect_dump("const", 32'sd100, 32'sd100);
    check("const_pulses", pulses0, 1);

    // Positive ramp, sum 36.
    for (int i = 1; i <= 8; i++) push(32'(i));
    expect_dump("ramp_pos", 32'sd4, 32'sd5);

    // Negative ramp, sum -36: floor gives -5, round half up gives -4.
    for (int i = 1; i <= 8; i++) push(-32'(i));
    expect_dump("ramp_neg", -32'sd5, -32'sd4);

    // Extremes, no wrap in the accumulator.
    for (int i = 0; i < 8; i++) push(32'sh7FFFFFFF);
    expect_dump("max", 32'sh7FFFFFFF, 32'sh7FFFFFFF);
    for (int i = 0; i < 8; i++) push($signed(32'h80000000));
    expect_dump("min", $signed(32'h80000000), $signed(32'h80000000));

    // Gapped input.
    pulses0 = 0;
    for (int i = 1; i <= 8; i++) begin
      push(32'sd10);
      if (i < 8) begin
        for (int g = 0; g < 3; g++) begin
          idle();
          check($sformatf("gap_cnt%0d_%0d", i, g), cnt0, i);
        end
      end
    end
    expect_dump("gap", 32'sd10, 32'sd10);
    check("gap_pulses", pulses0, 1);

    // Clear mid-frame with a coincident sample.
    for (int i = 0; i < 5; i++) push(32'sd50);
    step(1'b1, 32'sd50, 1'b1);
    check("clr_cnt", cnt0, 0);
    check("clr_ov", out_valid0, 0);
    for (int i = 0; i < 8; i++) push(32'sd20);
    expect_dump("clr", 32'sd20, 32'sd20);

    // Clear on the would-be dump edge suppresses the dump.
    pulses0 = 0;
    for (int i = 0; i < 7; i++) push(32'sd90);
    step(1'b1, 32'sd90, 1'b1);
    check("clr_dump_ov", out_valid0, 0);
    check("clr_dump_cnt", cnt0, 0);
    check("clr_dump_saida", saida0, 20);
    idle();
    check("clr_dump_pulses", pulses0, 0);

    // Reset mid-frame: asynchronous effect, then a fresh frame.
    for (int i = 0; i < 5; i++) push(32'sd50);
    reset = 1'b0;
    #1;
    check("rst_mid_cnt", cnt0, 0);
    check("rst_mid_saida", saida0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    idle();
    idle();
    idle();
    check("rst_mid_cnt_after", cnt0, 0);
    for (int i = 0; i < 8; i++) push(32'sd20);
    expect_dump("rst_mid", 32'sd20, 32'sd20);

    do_reset();
    check("final_cnt", cnt0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/decim_media.md
DECIM_MEDIA -- requirements
Module: decim_media

Interface
REQ-001 Parameter DATA_W, default 32, signed sample width of input and output.
REQ-002 Parameter LOG2_M, default 3, log2 of decimation factor M (M = 2**LOG2_M = 8).
REQ-003 Parameter ROUND, default 0, 0 = truncate (floor), 1 = round half up.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous frame restart, active-high.
REQ-007 in_valid  input  1  entrada holds a valid sample this cycle.
REQ-008 entrada  input  DATA_W  signed input sample, high-rate stream.
REQ-009 saida  output  DATA_W  signed decimated sample (block average of M inputs), registered.
REQ-010 out_valid  output  1  one-cycle strobe, saida updated this cycle.
REQ-011 cnt  output  LOG2_M  number of samples accumulated in current frame (0..M-1), registered.

Function
REQ-012 Integrate-and-dump decimator, the receive-side counterpart of the interpolating FIR: M valid input samples -> one output sample.
REQ-013 Accumulator acc signed, DATA_W+LOG2_M bits, sign-extended adds, never overflows for any M inputs.
REQ-014 States: FILL (cnt < M-1, accumulating) and DUMP_EDGE (in_valid=1 with cnt = M-1); no other states, no idle wait.
REQ-015 Edge with in_valid=1, clear=0, cnt < M-1: acc <= acc + entrada, cnt <= cnt+1, out_valid <= 0.
REQ-016 Edge with in_valid=1, clear=0, cnt = M-1: sum = acc + entrada; saida <= sum >>> LOG2_M (ROUND=0) or (sum + 2**(LOG2_M-1)) >>> LOG2_M (ROUND=1); out_valid <= 1; acc <= 0; cnt <= 0 (wrap).
REQ-017 ROUND=1 add uses one extra guard bit; result saturates to max positive if rounding pushes past 2**(DATA_W-1)-1.
REQ-018 Latency: saida/out_valid valid the cycle after the edge capturing the M-th sample (1 cycle).
REQ-019 out_valid high exactly one cycle per frame; saida holds its value until next dump.
REQ-020 Edge with in_valid=0: acc, cnt, saida unchanged; out_valid <= 0; gaps of any length allowed.
REQ-021 clear=1 on an edge: acc <= 0, cnt <= 0, out_valid <= 0, saida unchanged; coincident in_valid sample discarded (clear wins).
REQ-022 clear=1 when cnt = M-1 and in_valid=1: no dump, no out_valid.
REQ-023 Arithmetic shift is floor (toward -inf): negative averages truncate downward.

Reset
REQ-024 reset low forces immediately, independent of clk: acc=0, cnt=0, saida=0, out_valid=0.
REQ-025 reset asserted mid-frame discards partial frame; first output after release averages the next M valid samples.
REQ-026 Release of reset is synchronized internally (two-flop) so first accumulation occurs no earlier than the 2nd rising edge after release.

Verification
REQ-027 Reset: assert reset low with clk idle -> saida=0, out_valid=0, cnt=0 without any clock edge.
REQ-028 Constant: 8 valid samples of 100 -> cnt steps 1..7 then 0, saida=100, out_valid high one cycle after 8th edge.
REQ-029 Ramp 1..8 (sum 36): ROUND=0 -> saida=4; ROUND=1 -> saida=5; ramp -1..-8 ROUND=0 -> saida=-5.
REQ-030 Extremes: 8 x 0x7FFFFFFF -> 0x7FFFFFFF; 8 x 0x80000000 -> 0x80000000; no wrap.
REQ-031 Gaps: 8 samples of 10 with in_valid low 3 cycles between each -> cnt holds during gaps, single out_valid, saida=10.
REQ-032 Clear/reset mid-frame: 5 samples of 50, clear pulse, 8 samples of 20 -> saida=20 only; same sequence with reset pulse instead of clear -> saida=20.
